// File: rtl/mem_arbiter_if.sv
// Bundle of request, response and main-memory signals shared by mem_arbiter and its neighbours.
// The slave view belongs to the arbiter; the master view belongs to the requesters and memory.
interface mem_arbiter_if #(
   parameter int WCNT_W = 2
);
   logic              ireq;
   logic [31:0]       iaddr;
   logic [31:0]       irdata;
   logic              ivalid;
   logic [WCNT_W-1:0] iword;
   logic              idone;
   logic              dreq;
   logic              dwe;
   logic [31:0]       daddr;
   logic [31:0]       dwdata;
   logic [31:0]       drdata;
   logic              ddone;
   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      output ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rdata, mem_ack,
      input  irdata, ivalid, iword, idone, drdata, ddone,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rdata, mem_ack,
      output irdata, ivalid, iword, idone, drdata, ddone,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one main-memory port between I-cache line refills (bursts)
// and single-word data loads/stores, with alternating priority on conflict.
module mem_arbiter #(
   parameter int LINE_WORDS = 4,
   parameter int WCNT_W     = 2
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IFILL, DACC, FIN} state_t;

   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(LINE_WORDS - 1);
   localparam logic [31:0]       LINE_MASK = ~((32'd1 << (WCNT_W + 2)) - 32'd1);

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] cnt, cnt_nxt;
   logic              last_d, last_d_nxt;
   logic              req_q, req_nxt;
   logic              we_q, we_nxt;
   logic [31:0]       addr_q, addr_nxt;
   logic [31:0]       wdata_q, wdata_nxt;
   logic [31:0]       irdata_q, irdata_nxt;
   logic              ivalid_q, ivalid_nxt;
   logic [WCNT_W-1:0] iword_q, iword_nxt;
   logic              idone_q, idone_nxt;
   logic [31:0]       drdata_q, drdata_nxt;
   logic              ddone_q, ddone_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         last_d   <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         irdata_q <= '0;
         ivalid_q <= 1'b0;
         iword_q  <= '0;
         idone_q  <= 1'b0;
         drdata_q <= '0;
         ddone_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         last_d   <= last_d_nxt;
         req_q    <= req_nxt;
         we_q     <= we_nxt;
         addr_q   <= addr_nxt;
         wdata_q  <= wdata_nxt;
         irdata_q <= irdata_nxt;
         ivalid_q <= ivalid_nxt;
         iword_q  <= iword_nxt;
         idone_q  <= idone_nxt;
         drdata_q <= drdata_nxt;
         ddone_q  <= ddone_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      last_d_nxt = last_d;
      req_nxt    = req_q;
      we_nxt     = we_q;
      addr_nxt   = addr_q;
      wdata_nxt  = wdata_q;
      irdata_nxt = irdata_q;
      ivalid_nxt = 1'b0;
      iword_nxt  = iword_q;
      idone_nxt  = 1'b0;
      drdata_nxt = drdata_q;
      ddone_nxt  = 1'b0;

      case (state)
         IDLE: begin
            // On conflict the side that did not win last time is served.
            if (bus.ireq && (!bus.dreq || last_d)) begin
               state_nxt  = IFILL;
               cnt_nxt    = '0;
               last_d_nxt = 1'b0;
               req_nxt    = 1'b1;
               we_nxt     = 1'b0;
               addr_nxt   = bus.iaddr & LINE_MASK;
            end else if (bus.dreq) begin
               state_nxt  = DACC;
               last_d_nxt = 1'b1;
               req_nxt    = 1'b1;
               we_nxt     = bus.dwe;
               addr_nxt   = bus.daddr;
               wdata_nxt  = bus.dwdata;
            end
         end
         IFILL: begin
            if (bus.mem_ack) begin
               irdata_nxt = bus.mem_rdata;
               ivalid_nxt = 1'b1;
               iword_nxt  = cnt;
               cnt_nxt    = cnt + WCNT_W'(1);
               addr_nxt   = addr_q + 32'd4;
               if (cnt == LAST_WORD) begin
                  idone_nxt = 1'b1;
                  req_nxt   = 1'b0;
                  state_nxt = FIN;
               end
            end
         end
         DACC: begin
            if (bus.mem_ack) begin
               if (!we_q) drdata_nxt = bus.mem_rdata;
               ddone_nxt = 1'b1;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               state_nxt = FIN;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.irdata    = irdata_q;
   assign bus.ivalid    = ivalid_q;
   assign bus.iword     = iword_q;
   assign bus.idone     = idone_q;
   assign bus.drdata    = drdata_q;
   assign bus.ddone     = ddone_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a latency-programmable memory responder plus a
// reference memory model that predicts bus transfers, refill words and load results.
module tb_mem_arbiter;
   localparam int LW = 4;
   localparam int WW = 2;

   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} xfer_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.WCNT_W(WW)) bus ();
   mem_arbiter #(.LINE_WORDS(LW), .WCNT_W(WW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int nvec = 0;
   int nerr = 0;

   logic [31:0] memory  [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int    ack_delay = 0;
   bit    spur = 1'b0;
   xfer_t xq[$];
   int    hiq[$];
   int    loq[$];
   int    iv_word[$];
   logic [31:0] iv_data[$];
   bit    iv_last[$];
   bit    done_kind[$];
   int    n_idone = 0, n_ddone = 0, stray = 0, req_seen = 0;
   logic [31:0] last_drd = '0;
   logic [31:0] exp_drd = '0;
   logic [31:0] exp_irdata = '0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (memory.exists(a)) return memory[a];
      return a | 32'hA000_0000;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return a | 32'hA000_0000;
   endfunction

   function automatic logic [31:0] line_base(input logic [31:0] a);
      return a - (a % (LW * 4));
   endfunction

   function automatic xfer_t xq_at(input int i);
      xfer_t x = 'x;
      if (i < xq.size()) x = xq[i];
      return x;
   endfunction

   function automatic int ivw_at(input int i);
      return (i < iv_word.size()) ? iv_word[i] : -1;
   endfunction

   function automatic logic [31:0] ivd_at(input int i);
      return (i < iv_data.size()) ? iv_data[i] : 'x;
   endfunction

   function automatic logic ivl_at(input int i);
      return (i < iv_last.size()) ? iv_last[i] : 1'bx;
   endfunction

   // Memory responder and mem_req run-length monitor share one block so they never race.
   int wcnt = 0, run = 0;
   bit prev_req = 1'b0, seen_hi = 1'b0;
   always @(negedge clk) begin
      if (bus.mem_req !== prev_req) begin
         if (prev_req) hiq.push_back(run);
         else if (seen_hi) loq.push_back(run);
         run = 0;
      end
      if (bus.mem_req === 1'b1) seen_hi = 1'b1;
      run++;
      prev_req = (bus.mem_req === 1'b1);
      if (spur) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = $urandom;
      end else if (bus.mem_req === 1'b1) begin
         if (wcnt >= ack_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = bus.mem_we ? $urandom : mem_rd(bus.mem_addr);
            xq.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
            if (bus.mem_we) memory[bus.mem_addr] = bus.mem_wdata;
            wcnt = 0;
         end else begin
            bus.mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         bus.mem_ack = 1'b0;
         wcnt = 0;
      end
   end

   task automatic collect(input int target, input int budget, output int n);
      int dones = 0;
      n = 0;
      while (dones < target && n < budget) begin
         @(negedge clk);
         n++;
         if (bus.ivalid) begin
            iv_word.push_back(int'(bus.iword));
            iv_data.push_back(bus.irdata);
            iv_last.push_back(bus.idone);
         end
         if (bus.idone) begin n_idone++; dones++; done_kind.push_back(1'b0); end
         if (bus.ddone) begin n_ddone++; dones++; done_kind.push_back(1'b1); last_drd = bus.drdata; end
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         if (bus.ivalid || bus.idone || bus.ddone) stray++;
         if (bus.mem_req) req_seen++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.ireq = 1'($urandom); bus.iaddr = $urandom;
         bus.dreq = 1'($urandom); bus.dwe = 1'($urandom);
         bus.daddr = $urandom; bus.dwdata = $urandom;
         @(negedge clk);
         nvec++;
         if ({bus.mem_req, bus.mem_we, bus.ivalid, bus.idone, bus.ddone, bus.mem_addr,
              bus.mem_wdata, bus.irdata, bus.drdata, bus.iword} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs[%0d]: got req=%b we=%b iv=%b id=%b dd=%b addr=%h wd=%h ird=%h drd=%h iword=%0d expected all zero",
                     i, bus.mem_req, bus.mem_we, bus.ivalid, bus.idone, bus.ddone, bus.mem_addr,
                     bus.mem_wdata, bus.irdata, bus.drdata, bus.iword);
         end
      end
      reset = 1'b0; bus.ireq = 1'b0; bus.dreq = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.mem_req !== 1'b0) begin nerr++; $display("FAIL reset_release_req: got %b expected 0", bus.mem_req); end
      exp_drd = '0; exp_irdata = '0;
      idle(1);
   endtask

   task automatic test_refill;
      int xb, ivb, ni0, n;
      logic [31:0] base = 32'h0000_1040;
      xfer_t x;
      ack_delay = 0;
      @(negedge clk);
      xb = xq.size(); ivb = iv_word.size(); ni0 = n_idone;
      bus.iaddr = 32'h0000_104C; bus.ireq = 1'b1;
      collect(1, 20, n);
      bus.ireq = 1'b0;
      idle(2);
      nvec++;
      if (n !== LW + 1) begin nerr++; $display("FAIL refill_latency: got idone %0d edges after sampling, expected %0d", n - 1, LW); end
      nvec++;
      if (n_idone - ni0 !== 1) begin nerr++; $display("FAIL refill_idone_count: got %0d expected 1", n_idone - ni0); end
      nvec++;
      if (xq.size() - xb !== LW) begin nerr++; $display("FAIL refill_xfer_count: got %0d expected %0d", xq.size() - xb, LW); end
      for (int w = 0; w < LW; w++) begin
         x = xq_at(xb + w);
         nvec++;
         if ({x.we, x.addr} !== {1'b0, base + 32'(4 * w)}) begin
            nerr++; $display("FAIL refill_addr[%0d]: got we=%b addr=%h expected we=0 addr=%h", w, x.we, x.addr, base + 32'(4 * w));
         end
         nvec++;
         if ({ivw_at(ivb + w), ivd_at(ivb + w), ivl_at(ivb + w)} !== {w, ref_rd(base + 32'(4 * w)), (w == LW - 1)}) begin
            nerr++; $display("FAIL refill_word[%0d]: got iword=%0d irdata=%h idone=%b expected iword=%0d irdata=%h idone=%b",
                             w, ivw_at(ivb + w), ivd_at(ivb + w), ivl_at(ivb + w), w, ref_rd(base + 32'(4 * w)), (w == LW - 1));
         end
      end
      exp_irdata = ref_rd(base + 32'(4 * (LW - 1)));
   endtask

   task automatic test_load_wait;
      int xb, hb, nd0, n;
      xfer_t x;
      memory[32'h2000] = 32'hDEAD_BEEF; ref_mem[32'h2000] = 32'hDEAD_BEEF;
      ack_delay = 3;
      @(negedge clk);
      xb = xq.size(); hb = hiq.size(); nd0 = n_ddone;
      bus.daddr = 32'h2000; bus.dwe = 1'b0; bus.dwdata = $urandom; bus.dreq = 1'b1;
      collect(1, 30, n);
      bus.dreq = 1'b0;
      idle(4);
      exp_drd = ref_rd(32'h2000);
      nvec++;
      if (n !== ack_delay + 2) begin nerr++; $display("FAIL load_latency: got %0d expected %0d", n, ack_delay + 2); end
      nvec++;
      if (((hb < hiq.size()) ? hiq[hb] : -1) !== ack_delay + 1) begin
         nerr++; $display("FAIL load_req_cycles: got %0d expected %0d", (hb < hiq.size()) ? hiq[hb] : -1, ack_delay + 1);
      end
      x = xq_at(xb);
      nvec++;
      if ({xq.size() - xb, x.we, x.addr} !== {32'd1, 1'b0, 32'h2000}) begin
         nerr++; $display("FAIL load_xfer: got n=%0d we=%b addr=%h expected n=1 we=0 addr=00002000", xq.size() - xb, x.we, x.addr);
      end
      nvec++;
      if (last_drd !== exp_drd) begin nerr++; $display("FAIL load_drdata: got %h expected %h", last_drd, exp_drd); end
      nvec++;
      if (n_ddone - nd0 !== 1) begin nerr++; $display("FAIL load_ddone_count: got %0d expected 1", n_ddone - nd0); end
   endtask

   task automatic test_store;
      int xb, nd0, n, st0;
      xfer_t x;
      ack_delay = $urandom_range(0, 3);
      @(negedge clk);
      xb = xq.size(); nd0 = n_ddone; st0 = stray;
      bus.daddr = 32'h3004; bus.dwdata = 32'h1234_5678; bus.dwe = 1'b1; bus.dreq = 1'b1;
      collect(1, 30, n);
      bus.dreq = 1'b0; bus.dwe = 1'b0;
      idle(2);
      ref_mem[32'h3004] = 32'h1234_5678;
      x = xq_at(xb);
      nvec++;
      if ({xq.size() - xb, x} !== {32'd1, 1'b1, 32'h3004, 32'h1234_5678}) begin
         nerr++; $display("FAIL store_xfer: got n=%0d we=%b addr=%h data=%h expected n=1 we=1 addr=00003004 data=12345678",
                          xq.size() - xb, x.we, x.addr, x.wdata);
      end
      nvec++;
      if (bus.drdata !== exp_drd) begin nerr++; $display("FAIL store_drdata_kept: got %h expected %h", bus.drdata, exp_drd); end
      nvec++;
      if ({n_ddone - nd0, stray - st0} !== {32'd1, 32'd0}) begin
         nerr++; $display("FAIL store_ddone: got %0d pulses, %0d stray expected 1, 0", n_ddone - nd0, stray - st0);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 12; it++) begin
         int kind = $urandom_range(0, 2);
         bit early = 1'($urandom);
         logic [31:0] a = $urandom & ~32'd3;
         logic [31:0] wd = $urandom;
         logic [31:0] base;
         int xb, ivb, ni0, nd0, n;
         xfer_t x;
         if (kind == 1 && $urandom_range(0, 1) == 1) a = 32'h3004;
         ack_delay = $urandom_range(0, 2);
         @(negedge clk);
         xb = xq.size(); ivb = iv_word.size(); ni0 = n_idone; nd0 = n_ddone;
         if (kind == 0) begin
            bus.iaddr = a; bus.ireq = 1'b1;
         end else begin
            bus.daddr = a; bus.dwdata = wd; bus.dwe = (kind == 2); bus.dreq = 1'b1;
         end
         // Dropping the request right after the grant must not abort the transaction.
         if (early) begin @(negedge clk); bus.ireq = 1'b0; bus.dreq = 1'b0; end
         collect(1, 40, n);
         bus.ireq = 1'b0; bus.dreq = 1'b0;
         idle(2);
         if (kind == 0) begin
            base = line_base(a);
            nvec++;
            if ({n_idone - ni0, xq.size() - xb} !== {32'd1, 32'(LW)}) begin
               nerr++; $display("FAIL rnd%0d_refill_counts: got idone=%0d xfers=%0d expected 1, %0d", it, n_idone - ni0, xq.size() - xb, LW);
            end
            for (int w = 0; w < LW; w++) begin
               x = xq_at(xb + w);
               nvec++;
               if ({x.we, x.addr, ivw_at(ivb + w), ivd_at(ivb + w)} !== {1'b0, base + 32'(4 * w), w, ref_rd(base + 32'(4 * w))}) begin
                  nerr++; $display("FAIL rnd%0d_refill[%0d]: got addr=%h iword=%0d irdata=%h expected addr=%h iword=%0d irdata=%h",
                                   it, w, x.addr, ivw_at(ivb + w), ivd_at(ivb + w), base + 32'(4 * w), w, ref_rd(base + 32'(4 * w)));
               end
            end
            exp_irdata = ref_rd(base + 32'(4 * (LW - 1)));
         end else begin
            x = xq_at(xb);
            nvec++;
            if ({n_ddone - nd0, xq.size() - xb, x.we, x.addr} !== {32'd1, 32'd1, (kind == 2), a}) begin
               nerr++; $display("FAIL rnd%0d_data_xfer: got ddone=%0d xfers=%0d we=%b addr=%h expected 1, 1, we=%b addr=%h",
                                it, n_ddone - nd0, xq.size() - xb, x.we, x.addr, (kind == 2), a);
            end
            if (kind == 2) begin
               ref_mem[a] = wd;
               nvec++;
               if (x.wdata !== wd) begin nerr++; $display("FAIL rnd%0d_store_data: got %h expected %h", it, x.wdata, wd); end
            end else begin
               exp_drd = ref_rd(a);
            end
            nvec++;
            if (bus.drdata !== exp_drd) begin nerr++; $display("FAIL rnd%0d_drdata: got %h expected %h", it, bus.drdata, exp_drd); end
         end
      end
   endtask

   task automatic test_contention;
      int xb, kb, lb, n, j;
      logic [31:0] ca = $urandom & ~32'd3;
      logic [31:0] cbase = line_base($urandom);
      xfer_t x;
      ack_delay = 0;
      @(negedge clk);
      xb = xq.size(); kb = done_kind.size(); lb = loq.size();
      reset = 1'b1;
      bus.iaddr = cbase + 32'd8; bus.ireq = 1'b1;
      bus.daddr = ca; bus.dwe = 1'b0; bus.dreq = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      collect(6, 200, n);
      bus.ireq = 1'b0; bus.dreq = 1'b0;
      idle(3);
      exp_drd = ref_rd(ca);
      exp_irdata = ref_rd(cbase + 32'(4 * (LW - 1)));
      nvec++;
      if (xq.size() - xb !== 3 + 3 * LW) begin nerr++; $display("FAIL cont_xfer_count: got %0d expected %0d", xq.size() - xb, 3 + 3 * LW); end
      j = xb;
      for (int t = 0; t < 6; t++) begin
         nvec++;
         if (((kb + t < done_kind.size()) ? done_kind[kb + t] : 1'bx) !== (t % 2 == 0)) begin
            nerr++; $display("FAIL cont_grant_order[%0d]: got data=%b expected data=%b", t,
                             (kb + t < done_kind.size()) ? done_kind[kb + t] : 1'bx, (t % 2 == 0));
         end
         if (t % 2 == 0) begin
            x = xq_at(j); j++;
            nvec++;
            if ({x.we, x.addr} !== {1'b0, ca}) begin nerr++; $display("FAIL cont_daccess[%0d]: got we=%b addr=%h expected we=0 addr=%h", t, x.we, x.addr, ca); end
         end else begin
            for (int w = 0; w < LW; w++) begin
               x = xq_at(j); j++;
               nvec++;
               if ({x.we, x.addr} !== {1'b0, cbase + 32'(4 * w)}) begin
                  nerr++; $display("FAIL cont_burst[%0d][%0d]: got we=%b addr=%h expected we=0 addr=%h", t, w, x.we, x.addr, cbase + 32'(4 * w));
               end
            end
         end
      end
      for (int g = 1; g <= 5; g++) begin
         nvec++;
         if (((lb + g < loq.size()) ? loq[lb + g] : -1) !== 2) begin
            nerr++; $display("FAIL cont_gap[%0d]: got %0d low cycles expected 2", g, (lb + g < loq.size()) ? loq[lb + g] : -1);
         end
      end
      nvec++;
      if (last_drd !== exp_drd) begin nerr++; $display("FAIL cont_drdata: got %h expected %h", last_drd, exp_drd); end
   endtask

   task automatic test_robust;
      int nv = 0, sawdone = 0, t = 0, xb, ivb, ni0, n, st0, rq0;
      logic [31:0] ra = $urandom;
      logic [31:0] base = line_base(ra);
      xfer_t x;
      ack_delay = 0;
      @(negedge clk);
      bus.iaddr = ra; bus.ireq = 1'b1;
      while (nv < 2 && t < 20) begin
         @(negedge clk); t++;
         if (bus.ivalid) nv++;
         if (bus.idone) sawdone++;
      end
      nvec++;
      if (nv !== 2) begin nerr++; $display("FAIL robust_partial_words: got %0d expected 2", nv); end
      reset = 1'b1;
      @(negedge clk);
      nvec++;
      if ({bus.mem_req, bus.ivalid, bus.idone, sawdone} !== {3'b000, 32'd0}) begin
         nerr++; $display("FAIL robust_reset: got req=%b ivalid=%b idone=%b earlier_idone=%0d expected all 0",
                          bus.mem_req, bus.ivalid, bus.idone, sawdone);
      end
      reset = 1'b0;
      exp_drd = '0;
      xb = xq.size(); ivb = iv_word.size(); ni0 = n_idone;
      collect(1, 20, n);
      bus.ireq = 1'b0;
      idle(2);
      nvec++;
      if ({n_idone - ni0, xq.size() - xb} !== {32'd1, 32'(LW)}) begin
         nerr++; $display("FAIL robust_restart_counts: got idone=%0d xfers=%0d expected 1, %0d", n_idone - ni0, xq.size() - xb, LW);
      end
      for (int w = 0; w < LW; w++) begin
         x = xq_at(xb + w);
         nvec++;
         if ({x.addr, ivw_at(ivb + w), ivd_at(ivb + w)} !== {base + 32'(4 * w), w, ref_rd(base + 32'(4 * w))}) begin
            nerr++; $display("FAIL robust_restart[%0d]: got addr=%h iword=%0d irdata=%h expected addr=%h iword=%0d irdata=%h",
                             w, x.addr, ivw_at(ivb + w), ivd_at(ivb + w), base + 32'(4 * w), w, ref_rd(base + 32'(4 * w)));
         end
      end
      exp_irdata = ref_rd(base + 32'(4 * (LW - 1)));
      st0 = stray; rq0 = req_seen;
      spur = 1'b1;
      idle(4);
      spur = 1'b0;
      idle(2);
      nvec++;
      if ({stray - st0, req_seen - rq0} !== {32'd0, 32'd0}) begin
         nerr++; $display("FAIL spurious_ack: got %0d pulses, %0d req cycles expected 0, 0", stray - st0, req_seen - rq0);
      end
      nvec++;
      if ({bus.irdata, bus.drdata} !== {exp_irdata, exp_drd}) begin
         nerr++; $display("FAIL spurious_data_kept: got irdata=%h drdata=%h expected %h %h", bus.irdata, bus.drdata, exp_irdata, exp_drd);
      end
   endtask

   initial begin
      bus.ireq = 1'b0; bus.iaddr = '0; bus.dreq = 1'b0; bus.dwe = 1'b0;
      bus.daddr = '0; bus.dwdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      test_reset;
      test_refill;
      test_load_wait;
      test_store;
      test_random;
      test_contention;
      test_robust;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached with %0d miscompares so far", nerr);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle main-memory port between two requesters:
  - the instruction cache, for line refills on a miss;
  - the data memory path, for single-word loads and stores.
- Sits between the cache/data-memory blocks and the backing memory model.
- Sequences multi-word bursts for cache lines and grants fairly when both sides request at once.
- Signals completion to each side with a one-cycle done pulse, which the cache uses to release its stall.

Parameters:
- LINE_WORDS, 4, words per I-cache line. Power of 2, at least 2.
- WCNT_W, 2, width of the word counter. Equals log2(LINE_WORDS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- ireq  in  1  I-cache refill request. Held high until idone is seen.
- iaddr  in  32  miss byte address. Sampled at grant.
- irdata  out  32  refill word.
- ivalid  out  1  one-cycle pulse per refill word.
- iword  out  WCNT_W  index of the word currently on irdata.
- idone  out  1  one-cycle pulse marking the end of a refill.
- dreq  in  1  data access request. Held high until ddone is seen.
- dwe  in  1  1 = store, 0 = load. Sampled at grant.
- daddr  in  32  data byte address. Sampled at grant.
- dwdata  in  32  store data. Sampled at grant.
- drdata  out  32  load result.
- ddone  out  1  one-cycle pulse marking the end of a data access.
- mem_req  out  1  main-memory request, held until acknowledged.
- mem_we  out  1  main-memory write enable.
- mem_addr  out  32  main-memory byte address.
- mem_wdata  out  32  main-memory write data.
- mem_rdata  in  32  main-memory read data. Valid when mem_ack is high.
- mem_ack  in  1  transfer complete. Counted only while mem_req is high.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high.
  - All outputs are registered.
  - Reset values:
    - FSM = IDLE, word counter = 0, last_grant = I.
    - mem_req, mem_we, ivalid, idone, ddone = 0.
    - mem_addr, mem_wdata, irdata, drdata = 0; iword = 0.
- FSM states: IDLE, IFILL, DACC, FIN.
- IDLE:
  - Only ireq alone is high: go to IFILL, latch line base = iaddr with bits [WCNT_W+1:0] cleared, word counter = 0.
  - Only dreq alone is high: go to DACC, latch daddr, dwdata and dwe.
  - Both are high: grant the side not recorded in last_grant. Because last_grant resets to I, the first conflict after reset goes to data.
  - last_grant updates on every grant.
  - mem_req rises on the edge that leaves IDLE, so it is high in the first cycle of IFILL or DACC.
- IFILL:
  - mem_req = 1, mem_we = 0, mem_addr = base + 4*count.
  - Each edge with mem_ack = 1:
    - irdata <= mem_rdata; ivalid <= 1 for one cycle; iword <= count.
    - count increments and mem_addr advances.
    - Back-to-back acks are allowed, one word per cycle.
  - Word order is ascending from the line base. There is no critical-word-first and no wrap.
  - On the ack for word LINE_WORDS-1: idone <= 1 in the same cycle as the last ivalid, mem_req <= 0, go to FIN.
- DACC:
  - mem_req = 1, mem_we = latched dwe, mem_addr = latched daddr, mem_wdata = latched dwdata.
  - On mem_ack:
    - Load: drdata <= mem_rdata.
    - Store: drdata is unchanged.
    - ddone <= 1, mem_req <= 0, mem_we <= 0, go to FIN.
  - mem_req stays high through any number of wait cycles.
- FIN:
  - Lasts one cycle; done pulses are visible here.
  - ireq and dreq are ignored so a requester can drop its req. Go to IDLE.
  - Minimum gap between transactions: ack edge, then FIN, then IDLE (regrant), then mem_req high. That gives 2 idle cycles on mem_req.
- mem_ack with mem_req low (IDLE or FIN) is ignored.
- A requester dropping req mid-transaction does not abort it. The transaction completes and its done pulse is issued.
- Reset mid-transaction:
  - The next edge returns all state and outputs to reset values; mem_req is low after that edge.
  - The partial refill is discarded and no idone is produced.
- Latencies with zero-wait memory (ack in the first mem_req cycle):
  - Data access: dreq sampled at edge k, ddone high after edge k+1.
  - Refill: idone high after edge k+LINE_WORDS.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> all outputs 0, and mem_req stays 0 for the cycle after reset falls with no req.
- Refill: iaddr=0x0000104C, memory acks every cycle with rdata=addr|0xA0000000 -> mem_addr 0x1040, 0x1044, 0x1048, 0x104C; 4 ivalid pulses with iword 0..3 and irdata 0xA0001040..0xA000104C; idone coincides with the 4th pulse; idone high 4 cycles after ireq sampled.
- Data load with waits: daddr=0x2000, mem_ack delayed 3 cycles, rdata=0xDEADBEEF -> mem_req high 4 cycles, mem_we=0, drdata=0xDEADBEEF, single ddone pulse, then 2 cycles of mem_req low.
- Data store: daddr=0x3004, dwdata=0x12345678, dwe=1 -> mem_we=1 with matching addr and data while mem_req is high; ddone pulses; drdata keeps its previous value.
- Contention: ireq and dreq held continuously from reset -> grant order D, I, D, I…; no requester is starved; refill bursts are never interleaved with data accesses.
- Robustness: reset after the 2nd refill word -> no idone, mem_req low next cycle, and a new refill restarts at the line base. A spurious mem_ack while IDLE -> no ivalid or ddone.
